// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl_pkg
// Brief    : Register map, CON bit positions and TX sequencer states.
// Revision : 1.0
// ============================================================================
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_TXD = 2'd0;
    localparam logic [1:0] ADDR_RXD = 2'd1;
    localparam logic [1:0] ADDR_CON = 2'd2;

    localparam int CON_TX_INT_EN   = 0;
    localparam int CON_RX_INT_EN   = 1;
    localparam int CON_TX_DONE     = 2;
    localparam int CON_RX_NONEMPTY = 3;
    localparam int CON_TX_BUSY     = 4;
    localparam int CON_RX_OVF      = 5;
    localparam int CON_TX_FULL     = 6;
    localparam int CON_W           = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl_if
// Brief    : CPU peripheral bus between the host and the UART controller.
// Revision : 1.0
// ============================================================================
interface uart_ctrl_if;

    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr, rd, wr, wdata,
        input  rdata
    );

    modport slave (
        input  addr, rd, wr, wdata,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Brief    : Show-ahead synchronous FIFO; push and pop on a full FIFO both apply.
// Revision : 1.0
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl
// Brief    : Memory-mapped UART controller with RX/TX FIFOs and TX sequencer.
// Revision : 1.0
// ============================================================================
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  wire logic       sysclk,
    input  wire logic       reset,
    uart_ctrl_if.slave      bus,
    input  wire logic       rx_status,
    input  wire logic [7:0] rx_data,
    input  wire logic       tx_status,
    output logic            tx_en,
    output logic      [7:0] tx_data,
    output logic            irq
);

    localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    tx_state_e        state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_int_en_q, tx_int_en_d;
    logic             rx_int_en_q, rx_int_en_d;
    logic             tx_done_q, tx_done_d;
    logic             rx_ovf_q, rx_ovf_d;

    logic       rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       done_set;
    logic       con_rd;
    logic       tx_busy;
    logic [CON_W-1:0] con_val;
    logic       unused_wdata;

    assign unused_wdata = &{1'b0, bus.wdata[31:8]};

    assign rx_pop  = bus.rd && (bus.addr == ADDR_RXD);
    assign tx_push = bus.wr && (bus.addr == ADDR_TXD);
    assign con_rd  = bus.rd && (bus.addr == ADDR_CON);

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (sysclk),
        .rst_n (reset),
        .push  (rx_status),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (sysclk),
        .rst_n (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus.wdata[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // tx_data is captured on entry to SEND so it is already valid alongside tx_en.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        tx_data_d = tx_data_q;
        tx_en     = 1'b0;
        tx_pop    = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_empty && tx_status) begin
                    state_d   = ST_SEND;
                    tx_data_d = tx_head;
                end
            end
            ST_SEND: begin
                tx_en   = 1'b1;
                tx_pop  = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_status) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_status) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky bits: a new set event wins over a clear-on-read in the same cycle.
    always_comb begin
        tx_int_en_d = tx_int_en_q;
        rx_int_en_d = rx_int_en_q;
        if (bus.wr && (bus.addr == ADDR_CON)) begin
            tx_int_en_d = bus.wdata[CON_TX_INT_EN];
            rx_int_en_d = bus.wdata[CON_RX_INT_EN];
        end
        tx_done_d = done_set | (tx_done_q & ~con_rd);
        rx_ovf_d  = (rx_status && rx_full && !(rx_pop && !rx_empty))
                  | (rx_ovf_q & ~con_rd);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            tx_data_q   <= '0;
            tx_int_en_q <= 1'b0;
            rx_int_en_q <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            tx_data_q   <= tx_data_d;
            tx_int_en_q <= tx_int_en_d;
            rx_int_en_q <= rx_int_en_d;
            tx_done_q   <= tx_done_d;
            rx_ovf_q    <= rx_ovf_d;
        end
    end

    assign tx_busy = (state_q != ST_IDLE) || !tx_empty;

    always_comb begin
        con_val                  = '0;
        con_val[CON_TX_INT_EN]   = tx_int_en_q;
        con_val[CON_RX_INT_EN]   = rx_int_en_q;
        con_val[CON_TX_DONE]     = tx_done_q;
        con_val[CON_RX_NONEMPTY] = !rx_empty;
        con_val[CON_TX_BUSY]     = tx_busy;
        con_val[CON_RX_OVF]      = rx_ovf_q;
        con_val[CON_TX_FULL]     = tx_full;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            case (bus.addr)
                ADDR_RXD: bus.rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
                ADDR_CON: bus.rdata = {{(32-CON_W){1'b0}}, con_val};
                default:  bus.rdata = '0;
            endcase
        end
    end

    assign tx_data = tx_data_q;
    assign irq     = (tx_int_en_q & tx_done_q) | (rx_int_en_q & ~rx_empty);

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ctrl
// Brief    : Directed self-checking bench for uart_ctrl with RX/TX scoreboards.
// Revision : 1.0
// ============================================================================
module tb_uart_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rx_status;
    logic [7:0] rx_data;
    logic       tx_status;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       irq;

    uart_ctrl_if bus();

    uart_ctrl #(.FIFO_DEPTH(4), .BUSY_TIMEOUT(16)) dut (
        .sysclk    (clk),
        .reset     (rst_n),
        .bus       (bus.slave),
        .rx_status (rx_status),
        .rx_data   (rx_data),
        .tx_status (tx_status),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rx [$];
    logic [7:0] exp_tx [$];

    // Transmitter-side observations, written only by the monitor.
    int         tx_en_cnt = 0;
    int         cyc       = 0;
    logic [7:0] obs_data [64];
    int         obs_cyc  [64];
    int         obs_rd    = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_en && tx_en_cnt < 64) begin
                obs_data[tx_en_cnt] = tx_data;
                obs_cyc[tx_en_cnt]  = cyc;
                tx_en_cnt++;
            end
        end
    end

    // Transmitter model: goes busy 2 cycles after tx_en, idle again 100 later.
    logic tx_stuck = 1'b0;
    int   busy_cnt = 0;
    initial begin
        tx_status = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                tx_status = 1'b1;
                busy_cnt  = 0;
            end else if (tx_en && !tx_stuck) begin
                busy_cnt = 1;
            end else if (busy_cnt != 0) begin
                busy_cnt++;
                if (busy_cnt == 3) tx_status = 1'b0;
                if (busy_cnt == 103) begin
                    tx_status = 1'b1;
                    busy_cnt  = 0;
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        #2;
        d = bus.rdata;
        tick(1);
        bus.rd = 1'b0;
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        tick(1);
        bus.wr = 1'b0;
    endtask

    task automatic rx_push(logic [7:0] b);
        rx_data   = b;
        rx_status = 1'b1;
        if (exp_rx.size() < 4) exp_rx.push_back(b);
        tick(1);
        rx_status = 1'b0;
    endtask

    task automatic tx_write(logic [7:0] b);
        exp_tx.push_back(b);
        bus_write(2'd0, {24'd0, b});
    endtask

    task automatic tx_score(string tag);
        logic [7:0] o;
        logic [7:0] e;
        e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hxx;
        o = (obs_rd < tx_en_cnt) ? obs_data[obs_rd] : 8'hxx;
        obs_rd++;
        check(tag, {24'd0, o}, {24'd0, e});
    endtask

    task automatic wait_tx(int target, int budget, string tag);
        int n = 0;
        while (tx_en_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(tx_en_cnt >= target), 32'd1);
    endtask

    logic [31:0] rd_val;
    int          base;

    initial begin
        rst_n     = 1'b0;
        rx_status = 1'b0;
        rx_data   = 8'h00;
        bus.addr  = 2'd0;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.wdata = 32'd0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Reset state
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_tx_en", {31'd0, tx_en}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        check("reset_rdata_norm", bus.rdata, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd_val);
            check($sformatf("reset_read_addr%0d", a), rd_val, 32'd0);
        end
        check("reset_no_tx_en", tx_en_cnt, 32'd0);

        // RX in order
        rx_push(8'h41);
        rx_push(8'h42);
        bus_read(2'd2, rd_val);
        check("rx_con_nonempty", rd_val, 32'h08);
        bus_read(2'd1, rd_val);
        check("rx_pop1", rd_val, {24'd0, exp_rx.pop_front()});
        bus_read(2'd2, rd_val);
        check("rx_con_still", rd_val, 32'h08);
        bus_read(2'd1, rd_val);
        check("rx_pop2", rd_val, {24'd0, exp_rx.pop_front()});
        bus_read(2'd2, rd_val);
        check("rx_con_empty", rd_val, 32'h00);
        bus_read(2'd1, rd_val);
        check("rx_pop_empty", rd_val, 32'h00);

        // RX overflow: fifth byte dropped
        for (int i = 0; i < 5; i++) rx_push(8'h10 + 8'(i));
        bus_write(2'd2, 32'h2);
        check("rx_irq_on", {31'd0, irq}, 32'd1);
        bus_read(2'd2, rd_val);
        check("rx_con_ovf", rd_val, 32'h2A);
        bus_read(2'd2, rd_val);
        check("rx_con_ovf_clr", rd_val, 32'h0A);
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd1, rd_val);
            check($sformatf("rx_drain%0d", i), rd_val, {24'd0, exp_rx.pop_front()});
        end
        check("rx_irq_off", {31'd0, irq}, 32'd0);
        bus_read(2'd1, rd_val);
        check("rx_drain_empty", rd_val, 32'h00);

        // TX normal handshake
        bus_write(2'd2, 32'h1);
        base = tx_en_cnt;
        tx_write(8'h55);
        tx_write(8'hAA);
        wait_tx(base + 2, 400, "tx_two_pulses");
        tick(120);
        check("tx_pulse_count", tx_en_cnt, base + 2);
        tx_score("tx_byte0");
        tx_score("tx_byte1");
        check("tx_data_hold", {24'd0, tx_data}, 32'hAA);
        check("tx_irq_on", {31'd0, irq}, 32'd1);
        bus_read(2'd2, rd_val);
        check("tx_con_done", rd_val, 32'h05);
        check("tx_irq_off", {31'd0, irq}, 32'd0);

        // TX busy timeout: 1 SEND + 16 WAIT_BUSY + 1 IDLE between pulses
        tx_stuck = 1'b1;
        base = tx_en_cnt;
        tx_write(8'h33);
        tx_write(8'h66);
        wait_tx(base + 2, 100, "tmo_two_pulses");
        if (tx_en_cnt >= base + 2)
            check("tmo_gap", obs_cyc[base+1] - obs_cyc[base], 32'd18);
        tx_score("tmo_byte0");
        tx_score("tmo_byte1");
        tick(25);
        bus_read(2'd2, rd_val);
        check("tmo_con_done", rd_val, 32'h05);
        tx_stuck = 1'b0;

        // Reset while waiting for transmitter completion
        base = tx_en_cnt;
        tx_write(8'h01);
        tx_write(8'h02);
        tx_write(8'h03);
        wait_tx(base + 1, 20, "rst_first_pulse");
        tick(10);
        rst_n = 1'b0;
        #1;
        check("rst_tx_en", {31'd0, tx_en}, 32'd0);
        bus.addr = 2'd2;
        bus.rd   = 1'b1;
        #1;
        check("rst_con", bus.rdata, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        bus.rd = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(150);
        check("rst_no_more_tx", tx_en_cnt, base + 1);
        tx_score("rst_byte0");
        exp_tx.delete();
        bus_read(2'd2, rd_val);
        check("rst_con_after", rd_val, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Memory-mapped UART controller between the CPU peripheral bus and the UART receiver/transmitter pair. Buffers received bytes in an RX FIFO and queued transmit bytes in a TX FIFO. Sequences the transmitter one byte at a time from its TX FIFO. Exposes TXD/RXD/CON registers and a level interrupt.

Parameters:
FIFO_DEPTH, 4, entries per FIFO (power of two, >=2)
BUSY_TIMEOUT, 16, sysclk cycles to wait for transmitter to go busy before abandoning handshake

Ports:
sysclk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
addr  in  2  register select: 0=TXD, 1=RXD, 2=CON, 3=reserved
rd  in  1  bus read strobe (one cycle)
wr  in  1  bus write strobe (one cycle)
wdata  in  32  bus write data
rdata  out  32  bus read data (combinational from addr/rd)
rx_status  in  1  one-cycle pulse from receiver: rx_data valid
rx_data  in  8  received byte
tx_status  in  1  transmitter idle/ready (1 = idle)
tx_en  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to transmit, held stable from tx_en until next tx_en
irq  out  1  level interrupt

Behaviour:
- Reset (async, reset=0): FIFOs empty, FSM IDLE, tx_en=0, tx_data=0, CON enables/sticky bits 0, irq=0; rdata=0 (no rd asserted).
- rdata: rd=0 -> 0. addr 0 -> 0. addr 1 -> {24'b0, RX head} or 0 if empty. addr 2 -> {25'b0, CON[6:0]}. addr 3 -> 0.
- CON bits: [0] tx_int_en RW; [1] rx_int_en RW; [2] tx_done sticky, clear-on-read; [3] rx_nonempty RO; [4] tx_busy RO (FSM!=IDLE or TX FIFO nonempty); [5] rx_ovf sticky, clear-on-read; [6] tx_full RO.
- CON write: only bits [1:0] take wdata[1:0]; others ignored.
- RX push: rx_status=1 pushes rx_data. Full with no pop same cycle -> byte dropped, rx_ovf<=1.
- RX pop: rd with addr=1 and non-empty pops at the clock edge; data visible combinationally in that cycle. Pop on empty: no effect.
- Simultaneous RX push+pop: both occur; count unchanged; legal when full (no overflow).
- TX push: wr with addr=0 pushes wdata[7:0]; full -> write dropped, no flag. Writes to RXD/reserved ignored.
- Simultaneous TX push+FSM pop when full: both occur.
- TX FSM:
  IDLE: TX FIFO non-empty and tx_status=1 -> SEND.
  SEND (1 cycle): tx_en=1, tx_data<=head, pop TX FIFO -> WAIT_BUSY, timeout counter cleared.
  WAIT_BUSY: tx_status=0 -> WAIT_DONE; counter reaches BUSY_TIMEOUT-1 -> IDLE, tx_done<=1.
  WAIT_DONE: tx_status=1 -> IDLE, tx_done<=1.
- Sticky set and clear-on-read in same cycle: set wins (bit stays 1).
- irq = (tx_int_en & tx_done) | (rx_int_en & rx_nonempty), registered-state combinational, no extra latency.
- Back-to-back: min 4 cycles between successive tx_en pulses (SEND, WAIT_BUSY, WAIT_DONE, IDLE).
- Reset mid-transfer: FSM to IDLE, queued bytes lost; tx_en deasserted immediately.

Decomposition:
- Package uart_ctrl_pkg: register offsets (TXD=0, RXD=1, CON=2), CON bit indices, FSM state encoding (IDLE, SEND, WAIT_BUSY, WAIT_DONE).
- Sub-module uart_fifo: sync FIFO, params WIDTH=8 / DEPTH; ports push, pop, din, dout (show-ahead), full, empty; push+pop when full both honoured. Instanced twice (RX, TX).

Test Plan:
- Reset then idle -> rdata=0 for all addr with rd=1; irq=0; tx_en never asserted.
- Pulse rx_status with 0x41, 0x42; read RXD twice -> 0x41, then 0x42; CON[3] 1 then 0; third read -> 0.
- 5 rx_status pulses with DEPTH=4, no reads -> 4 bytes retained (first four), CON[5]=1; next CON read clears it.
- Write TXD 0x55, 0xAA; transmitter model drops tx_status 2 cycles after tx_en, raises 100 cycles later -> tx_data 0x55 then 0xAA, two tx_en pulses, tx_done set; CON[0]=1 -> irq=1 until CON read.
- tx_status held 1 after tx_en -> FSM returns IDLE after 16 cycles, tx_done=1, next byte sent.
- Assert reset during WAIT_DONE with 2 bytes queued -> tx_en=0, CON[4]=0, no further tx_en after reset release.
